rvfi_commit_queue: RTL and testbench

- Parametrised successor to the single-lane RVFI commit/order tracker in the top level.
- Accepts up to LANES retiring instructions per cycle from the writeback stage(s).
- Stamps each retiring instruction with a monotonic 64-bit order.
- Buffers packets in a circular queue and drains them in program order, one per cycle, to the monitor port, with backpressure.
- Sits beside the cpu in the top level. Used for dual-issue/superscalar retirement and for monitors that cannot absorb bursts.

---
 rtl/rvfi_commit_queue_pkg.sv | 26 ++
 rtl/rvfi_commit_queue_fifo_mw.sv | 64 ++++++
 rtl/rvfi_commit_queue.sv | 80 ++++++++
 tb/tb_rvfi_commit_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_commit_queue_pkg.sv
// Shared types for the RVFI commit queue: retirement packet layout and order width.
package rvfi_commit_queue_pkg;

  localparam int unsigned ORDER_W = 64;

  // mem_addr is a word address; byte lanes are carried by the masks.
  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_pkt_t;

  localparam int unsigned RVFI_PKT_W = $bits(rvfi_pkt_t);

endpackage

// File: rtl/rvfi_commit_queue_fifo_mw.sv
// Circular buffer taking up to LANES pre-compacted writes per cycle and one read.
// The head entry is held in a register so outputs are clean after reset.
module rvfi_commit_queue_fifo_mw #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 373
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(LANES+1)-1:0]    wr_cnt,
  input  logic [LANES-1:0][W-1:0]       wr_data,
  input  logic                          rd_en,
  output logic [W-1:0]                  rd_data,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NW = $clog2(LANES + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_rd;
  logic [CW-1:0] count_after_rd;
  logic [W-1:0]  head_n;

  assign do_rd = rd_en && (count != '0);

  // Next head: an already-stored entry if one remains, else the oldest incoming write.
  always_comb begin
    count_after_rd = count - CW'(do_rd);
    head_n         = rd_data;
    if (count_after_rd != '0) begin
      head_n = mem[rd_ptr + PW'(do_rd)];
    end else if (wr_cnt != '0) begin
      head_n = wr_data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(do_rd);
      wr_ptr  <= wr_ptr + PW'(wr_cnt);
      count   <= count_after_rd + CW'(wr_cnt);
      rd_data <= head_n;
    end
  end

  // Storage is unreset; validity is defined by the pointers and count.
  always_ff @(posedge clk) begin
    for (int s = 0; s < LANES; s++) begin
      if (NW'(s) < wr_cnt) begin
        mem[wr_ptr + PW'(s)] <= wr_data[s];
      end
    end
  end

endmodule

// File: rtl/rvfi_commit_queue.sv
// Multi-lane RVFI commit tracker: compacts retiring lanes, stamps program order,
// and drains one packet per cycle to the monitor with backpressure.
module rvfi_commit_queue
  import rvfi_commit_queue_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PKT_W = RVFI_PKT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES-1:0]          commit_valid,
  input  logic [LANES*PKT_W-1:0]    commit_pkt,
  output logic                      commit_ready,
  output logic                      mon_valid,
  output logic [ORDER_W-1:0]        mon_order,
  output logic [PKT_W-1:0]          mon_pkt,
  input  logic                      mon_ready,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned NW = $clog2(LANES + 1);
  localparam int unsigned EW = ORDER_W + PKT_W;

  logic [ORDER_W-1:0]        order_ctr;
  logic [LANES:0][NW-1:0]    pre;
  logic [NW-1:0]             wr_cnt;
  logic [LANES-1:0][EW-1:0]  comp;
  logic [EW-1:0]             head;

  assign commit_ready = (CW'(DEPTH) - occupancy) >= CW'(LANES);
  assign mon_valid    = occupancy != '0;

  // Lane i lands in slot pre[i] (count of valid older lanes) and takes order_ctr + slot.
  always_comb begin
    pre    = '0;
    comp   = '0;
    for (int i = 0; i < LANES; i++) begin
      pre[i+1] = pre[i] + NW'(commit_valid[i]);
    end
    for (int s = 0; s < LANES; s++) begin
      for (int i = 0; i < LANES; i++) begin
        if (commit_valid[i] && (pre[i] == NW'(s))) begin
          comp[s] = {order_ctr + ORDER_W'(s), commit_pkt[i*PKT_W +: PKT_W]};
        end
      end
    end
    wr_cnt = commit_ready ? pre[LANES] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      order_ctr <= '0;
      overflow  <= 1'b0;
    end else begin
      order_ctr <= order_ctr + ORDER_W'(wr_cnt);
      overflow  <= overflow | ((|commit_valid) & ~commit_ready);
    end
  end

  rvfi_commit_queue_fifo_mw #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_cnt  (wr_cnt),
    .wr_data (comp),
    .rd_en   (mon_valid && mon_ready),
    .rd_data (head),
    .count   (occupancy)
  );

  assign mon_order = head[EW-1 -: ORDER_W];
  assign mon_pkt   = head[PKT_W-1:0];

endmodule

// File: tb/tb_rvfi_commit_queue.sv
// Directed bench for rvfi_commit_queue with LANES=2, DEPTH=8.
module tb_rvfi_commit_queue;
  import rvfi_commit_queue_pkg::*;

  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PKT_W = RVFI_PKT_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [LANES-1:0]       commit_valid;
  logic [LANES*PKT_W-1:0] commit_pkt;
  logic                   commit_ready;
  logic                   mon_valid;
  logic [63:0]            mon_order;
  logic [PKT_W-1:0]       mon_pkt;
  logic                   mon_ready;
  logic [3:0]             occupancy;
  logic                   overflow;

  int checks = 0;
  int errors = 0;

  rvfi_commit_queue #(.LANES(LANES), .DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_pkt   (commit_pkt),
    .commit_ready (commit_ready),
    .mon_valid    (mon_valid),
    .mon_order    (mon_order),
    .mon_pkt      (mon_pkt),
    .mon_ready    (mon_ready),
    .occupancy    (occupancy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic rvfi_pkt_t mk(input logic [31:0] inst);
    rvfi_pkt_t p;
    p          = '0;
    p.inst     = inst;
    p.pc_rdata = inst << 2;
    p.rd_wdata = ~inst;
    p.rd_addr  = inst[4:0];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk(tag, 320'(obs), 320'(exp));
  endtask

  task automatic chk_p(input string tag, input logic [31:0] inst);
    chk(tag, 320'(mon_pkt), 320'(mk(inst)));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
    commit_valid = v;
    commit_pkt   = {mk(i1), mk(i0)};
  endtask

  task automatic do_reset;
    rst = 1'b1;
    commit_valid = '0;
    tick;
    rst = 1'b0;
  endtask

  int exp_occ [6] = '{2, 3, 4, 5, 6, 7};

  initial begin
    rst = 1'b1; commit_valid = '0; commit_pkt = '0; mon_ready = 1'b0;
    tick; tick;
    chk_v("rst_occ", 64'(occupancy), 0);
    chk_v("rst_mon_valid", 64'(mon_valid), 0);
    chk_v("rst_mon_order", mon_order, 0);
    chk("rst_mon_pkt", 320'(mon_pkt), 320'(0));
    chk_v("rst_overflow", 64'(overflow), 0);
    chk_v("rst_ready", 64'(commit_ready), 1);
    rst = 1'b0;

    // Dual commit drains in lane order.
    mon_ready = 1'b1;
    drive(2'b11, 32'h0000_0013, 32'h0010_0093);
    tick;
    commit_valid = '0;
    chk_v("t1_valid0", 64'(mon_valid), 1);
    chk_v("t1_order0", mon_order, 0);
    chk_p("t1_pkt0", 32'h0000_0013);
    chk_v("t1_occ", 64'(occupancy), 2);
    tick;
    chk_v("t1_order1", mon_order, 1);
    chk_p("t1_pkt1", 32'h0010_0093);
    tick;
    chk_v("t1_empty", 64'(mon_valid), 0);

    // Compaction of a lone lane-1 commit, then single-lane commits.
    do_reset;
    mon_ready = 1'b0;
    drive(2'b10, 32'h0, 32'hAA);
    tick;
    chk_v("t2_order0", mon_order, 0);
    chk_p("t2_pkt0", 32'hAA);
    chk_v("t2_occ1", 64'(occupancy), 1);
    for (int k = 1; k < 4; k++) begin
      drive(2'b01, 32'h100 + 32'(k), 32'h0);
      tick;
    end
    commit_valid = '0;
    chk_v("t2_occ4", 64'(occupancy), 4);
    mon_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_v("t2_drain_order", mon_order, 64'(k));
      chk_p("t2_drain_pkt", (k == 0) ? 32'hAA : 32'h100 + 32'(k));
      tick;
    end
    chk_v("t2_empty", 64'(mon_valid), 0);

    // Fill to full, reject on overflow, drain in order.
    do_reset;
    mon_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(2'b11, 32'h200 + 32'(2*j), 32'h200 + 32'(2*j+1));
      tick;
      chk_v("t3_occ", 64'(occupancy), 64'(2*j+2));
      chk_v("t3_ready", 64'(commit_ready), (j < 3) ? 64'd1 : 64'd0);
    end
    drive(2'b11, 32'h300, 32'h301);
    tick;
    commit_valid = '0;
    chk_v("t3_ovf_occ", 64'(occupancy), 8);
    chk_v("t3_overflow", 64'(overflow), 1);
    mon_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk_v("t3_drain_order", mon_order, 64'(k));
      chk_p("t3_drain_pkt", 32'h200 + 32'(k));
      tick;
    end
    chk_v("t3_empty", 64'(mon_valid), 0);
    chk_v("t3_overflow_sticky", 64'(overflow), 1);

    // Steady dual commit against single-entry drain.
    do_reset;
    mon_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      drive(2'b11, 32'h400 + 32'(2*j), 32'h400 + 32'(2*j+1));
      tick;
      chk_v("t4_occ", 64'(occupancy), 64'(exp_occ[j]));
      chk_v("t4_ready", 64'(commit_ready), (exp_occ[j] <= 6) ? 64'd1 : 64'd0);
      chk_v("t4_head_order", mon_order, 64'(j));
    end
    commit_valid = '0;
    chk_v("t4_no_overflow", 64'(overflow), 0);
    for (int k = 0; k < 7; k++) tick;
    chk_v("t4_empty", 64'(mon_valid), 0);

    // Order counter wraps modulo 2^64.
    do_reset;
    mon_ready = 1'b0;
    force dut.order_ctr = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(2'b11, 32'h600, 32'h601);
    tick;
    release dut.order_ctr;
    commit_valid = '0;
    chk_v("t5_order_max", mon_order, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_v("t5_occ", 64'(occupancy), 2);
    mon_ready = 1'b1;
    tick;
    chk_v("t5_order_wrap", mon_order, 0);
    chk_p("t5_pkt_wrap", 32'h601);

    // Reset mid-burst discards the queue.
    do_reset;
    mon_ready = 1'b0;
    drive(2'b11, 32'h700, 32'h701); tick;
    drive(2'b11, 32'h702, 32'h703); tick;
    drive(2'b01, 32'h704, 32'h0);   tick;
    chk_v("t6_occ5", 64'(occupancy), 5);
    rst = 1'b1;
    drive(2'b11, 32'h705, 32'h706);
    tick;
    rst = 1'b0;
    commit_valid = '0;
    chk_v("t6_occ0", 64'(occupancy), 0);
    chk_v("t6_valid0", 64'(mon_valid), 0);
    chk_v("t6_overflow0", 64'(overflow), 0);
    chk_v("t6_ready", 64'(commit_ready), 1);
    drive(2'b01, 32'h800, 32'h0);
    tick;
    commit_valid = '0;
    chk_v("t6_first_order", mon_order, 0);
    chk_p("t6_first_pkt", 32'h800);
    chk_v("t6_occ1", 64'(occupancy), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
